spi_flash_reg_bank: RTL and testbench

//  Parametrised AHB-side register bank for the SPI flash controller, next generation of the fixed 10-word bank.

---
 rtl/spi_flash_reg_bank.sv | 220 ++++++++++++++++++++++
 tb/tb_spi_flash_reg_bank.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reg_bank.sv
// rtl/spi_flash_reg_bank.sv - AHB-side register bank for the SPI flash controller
//
// Purpose: configuration, data-buffer, status and interrupt registers between
// the AHB slave adapter and the SPI engine. Single clock domain (i_clk_ahb).
//
// Word map (byte address >> 2):
//   0 CTRL  1 FLASH_ADDR  2 XFER_LEN  3 CLK_DIV  4..4+NUM_DATA-1 DATA
//   4+NUM_DATA STATUS  5+NUM_DATA INT_STAT  6+NUM_DATA INT_EN
//
// Ports:
//   i_clk_ahb, i_rstn_ahb          clock, async active-low reset
//   i_valid/i_rd0_wr1/i_address    bus transaction (always accepted, o_ready=1)
//   i_wr_data/i_byte_en            write data and byte strobes
//   o_rd_data/o_rd_valid           registered read response (latency 1)
//   o_err                          one-cycle error response
//   o_mode/o_go                    transfer mode and start pulse to SPI engine
//   o_flash_addr/o_xfer_len        transfer address and length
//   o_clk_div                      SPI clock divider (never 0)
//   o_tx_data                      data buffer, word k at [32k+31:32k]
//   i_busy/i_done                  engine busy level, transfer-done pulse
//   i_rx_we/i_rx_idx/i_rx_data     engine write port into the data buffer
//   o_irq                          only when SPI_REG_BANK_IRQ_EN is defined

module spi_flash_reg_bank #(
  parameter int NUM_DATA = 4,
  parameter int LEN_W    = 24,
  parameter int DIV_W    = 8
) (
  input  logic                    i_clk_ahb,
  input  logic                    i_rstn_ahb,
  input  logic                    i_valid,
  input  logic                    i_rd0_wr1,
  input  logic [31:0]             i_address,
  input  logic [31:0]             i_wr_data,
  input  logic [3:0]              i_byte_en,
  output logic                    o_ready,
  output logic [31:0]             o_rd_data,
  output logic                    o_rd_valid,
  output logic                    o_err,
  output logic [3:0]              o_mode,
  output logic                    o_go,
  output logic [LEN_W-1:0]        o_flash_addr,
  output logic [LEN_W-1:0]        o_xfer_len,
  output logic [DIV_W-1:0]        o_clk_div,
  output logic [32*NUM_DATA-1:0]  o_tx_data,
  input  logic                    i_busy,
  input  logic                    i_done,
  input  logic                    i_rx_we,
  input  logic [3:0]              i_rx_idx,
  input  logic [31:0]             i_rx_data
`ifdef SPI_REG_BANK_IRQ_EN
  ,
  output logic                    o_irq
`endif
);

  localparam logic [29:0] IDX_CTRL     = 30'd0;
  localparam logic [29:0] IDX_DATA0    = 30'd4;
  localparam logic [29:0] IDX_STATUS   = 30'(4 + NUM_DATA);
  localparam logic [29:0] IDX_INT_STAT = 30'(5 + NUM_DATA);
  localparam logic [29:0] IDX_INT_EN   = 30'(6 + NUM_DATA);

  // Registers
  logic [3:0]        r_mode;
  logic [LEN_W-1:0]  r_flash_addr;
  logic [LEN_W-1:0]  r_xfer_len;
  logic [DIV_W-1:0]  r_clk_div;
  logic [31:0]       r_data [NUM_DATA];
  logic [1:0]        r_int_stat;
  logic [1:0]        r_int_en;
  logic [31:0]       r_rd_data;
  logic              r_rd_valid;
  logic              r_err;
  logic              r_go;

  // Decode
  logic [29:0]       w_idx;
  logic [29:0]       w_data_off;
  logic [3:0]        w_data_k;
  logic              w_wr;
  logic              w_rd;
  logic              w_oob;
  logic              w_cfg;
  logic              w_is_data;
  logic              w_cfg_wr_ok;
  logic              w_err;
  logic              w_go;
  logic [31:0]       w_bmask;
  logic [1:0]        w_w1c;
  logic [1:0]        w_int_stat_next;
  logic [1:0]        w_int_en_next;
  logic [LEN_W-1:0]  w_fa_merge;
  logic [LEN_W-1:0]  w_xl_merge;
  logic [DIV_W-1:0]  w_cd_merge;
  logic [DIV_W-1:0]  w_cd_next;
  logic [31:0]       w_rd_val;
  logic              w_unused_bits;

  assign w_idx      = i_address[31:2];
  assign w_data_off = w_idx - IDX_DATA0;
  assign w_data_k   = w_data_off[3:0];
  assign w_wr       = i_valid & i_rd0_wr1;
  assign w_rd       = i_valid & ~i_rd0_wr1;
  assign w_oob      = (w_idx > IDX_INT_EN);
  assign w_cfg      = (w_idx < IDX_DATA0);
  assign w_is_data  = (w_idx >= IDX_DATA0) && (w_idx < IDX_STATUS);

  assign w_unused_bits = ^{i_address[1:0], w_data_off[29:4]};

  // Config registers are frozen while the engine runs; touching them is an error.
  assign w_cfg_wr_ok = w_wr & w_cfg & ~i_busy;
  assign w_err       = ((w_wr | w_rd) & w_oob) | (w_wr & w_cfg & i_busy);
  // GO lives in byte 1, so its strobe must be set for the start to count.
  assign w_go        = w_cfg_wr_ok & (w_idx == IDX_CTRL) & i_byte_en[1] & i_wr_data[8];

  assign w_bmask = {{8{i_byte_en[3]}}, {8{i_byte_en[2]}},
                    {8{i_byte_en[1]}}, {8{i_byte_en[0]}}};

  assign w_fa_merge = LEN_W'((32'(r_flash_addr) & ~w_bmask) | (i_wr_data & w_bmask));
  assign w_xl_merge = LEN_W'((32'(r_xfer_len)   & ~w_bmask) | (i_wr_data & w_bmask));
  assign w_cd_merge = DIV_W'((32'(r_clk_div)    & ~w_bmask) | (i_wr_data & w_bmask));
  // A zero divider would stall the SPI clock; clamp it to the fastest legal value.
  assign w_cd_next  = (w_cd_merge == '0) ? DIV_W'(1) : w_cd_merge;

  // Set is OR-ed after the clear so a simultaneous event is never lost.
  assign w_w1c = (w_wr && (w_idx == IDX_INT_STAT) && i_byte_en[0]) ? i_wr_data[1:0] : 2'b00;
  assign w_int_stat_next = (r_int_stat & ~w_w1c) | {w_err, i_done};
  assign w_int_en_next   = (w_wr && (w_idx == IDX_INT_EN) && i_byte_en[0]) ? i_wr_data[1:0]
                                                                          : r_int_en;

  // Read mux; out-of-map words fall through to 0.
  always_comb begin
    w_rd_val = 32'd0;
    if (w_cfg) begin
      case (w_idx[1:0])
        2'd0:    w_rd_val = {28'd0, r_mode};
        2'd1:    w_rd_val = 32'(r_flash_addr);
        2'd2:    w_rd_val = 32'(r_xfer_len);
        default: w_rd_val = 32'(r_clk_div);
      endcase
    end else if (w_is_data) begin
      for (int k = 0; k < NUM_DATA; k++) begin
        if (w_data_k == 4'(k)) w_rd_val = r_data[k];
      end
    end else if (w_idx == IDX_STATUS) begin
      w_rd_val = {30'd0, r_go, i_busy};
    end else if (w_idx == IDX_INT_STAT) begin
      w_rd_val = {30'd0, r_int_stat};
    end else if (w_idx == IDX_INT_EN) begin
      w_rd_val = {30'd0, r_int_en};
    end
  end

  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) begin
      r_mode       <= '0;
      r_flash_addr <= '0;
      r_xfer_len   <= '0;
      r_clk_div    <= DIV_W'(1);
      for (int k = 0; k < NUM_DATA; k++) r_data[k] <= '0;
      r_int_stat   <= '0;
      r_int_en     <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_err        <= 1'b0;
      r_go         <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) r_rd_data <= w_rd_val;
      r_err <= w_err;
      r_go  <= w_go;

      if (w_cfg_wr_ok) begin
        case (w_idx[1:0])
          2'd0:    if (i_byte_en[0]) r_mode <= i_wr_data[3:0];
          2'd1:    r_flash_addr <= w_fa_merge;
          2'd2:    r_xfer_len   <= w_xl_merge;
          default: r_clk_div    <= w_cd_next;
        endcase
      end

      // Engine write has priority over a bus write to the same word.
      for (int k = 0; k < NUM_DATA; k++) begin
        if (i_rx_we && (i_rx_idx == 4'(k))) begin
          r_data[k] <= i_rx_data;
        end else if (w_wr && w_is_data && (w_data_k == 4'(k))) begin
          r_data[k] <= (r_data[k] & ~w_bmask) | (i_wr_data & w_bmask);
        end
      end

      r_int_stat <= w_int_stat_next;
      r_int_en   <= w_int_en_next;
    end
  end

`ifdef SPI_REG_BANK_IRQ_EN
  logic r_irq;
  // Built from next-state values so o_irq tracks INT_STAT/INT_EN without extra lag.
  always_ff @(posedge i_clk_ahb or negedge i_rstn_ahb) begin
    if (!i_rstn_ahb) r_irq <= 1'b0;
    else             r_irq <= |(w_int_stat_next & w_int_en_next);
  end
  assign o_irq = r_irq;
`endif

  assign o_ready      = 1'b1;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_err        = r_err;
  assign o_go         = r_go;
  assign o_mode       = r_mode;
  assign o_flash_addr = r_flash_addr;
  assign o_xfer_len   = r_xfer_len;
  assign o_clk_div    = r_clk_div;

  for (genvar g = 0; g < NUM_DATA; g++) begin : g_tx
    assign o_tx_data[32*g +: 32] = r_data[g];
  end

endmodule

// File: tb/tb_spi_flash_reg_bank.sv
// tb/tb_spi_flash_reg_bank.sv - self-checking bench for spi_flash_reg_bank

module tb_spi_flash_reg_bank;

  localparam int ND = 4;
  localparam int LW = 24;
  localparam int DW = 8;
  localparam int NW = 7 + ND;

  logic              clk;
  logic              rst_n;
  logic              valid;
  logic              rd0_wr1;
  logic [31:0]       address;
  logic [31:0]       wr_data;
  logic [3:0]        byte_en;
  logic              ready;
  logic [31:0]       rd_data;
  logic              rd_valid;
  logic              err;
  logic [3:0]        mode;
  logic              go;
  logic [LW-1:0]     flash_addr;
  logic [LW-1:0]     xfer_len;
  logic [DW-1:0]     clk_div;
  logic [32*ND-1:0]  tx_data;
  logic              busy;
  logic              done;
  logic              rx_we;
  logic [3:0]        rx_idx;
  logic [31:0]       rx_data;
`ifdef SPI_REG_BANK_IRQ_EN
  logic              irq;
`endif

  spi_flash_reg_bank #(.NUM_DATA(ND), .LEN_W(LW), .DIV_W(DW)) dut (
    .i_clk_ahb(clk), .i_rstn_ahb(rst_n), .i_valid(valid), .i_rd0_wr1(rd0_wr1),
    .i_address(address), .i_wr_data(wr_data), .i_byte_en(byte_en),
    .o_ready(ready), .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_err(err),
    .o_mode(mode), .o_go(go), .o_flash_addr(flash_addr), .o_xfer_len(xfer_len),
    .o_clk_div(clk_div), .o_tx_data(tx_data), .i_busy(busy), .i_done(done),
    .i_rx_we(rx_we), .i_rx_idx(rx_idx), .i_rx_data(rx_data)
`ifdef SPI_REG_BANK_IRQ_EN
    , .o_irq(irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one 32-bit value per mapped word, as software would read it.
  logic [31:0] m_w [NW];
  logic        m_go_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) m_w[i] = 32'd0;
    m_w[3]    = 32'd1;
    m_go_prev = 1'b0;
  endtask

  function automatic logic [31:0] field_mask(input int idx);
    case (idx)
      0:       return 32'h0000_000F;
      1, 2:    return 32'((64'd1 << LW) - 1);
      3:       return 32'((64'd1 << DW) - 1);
      NW - 1:  return 32'h0000_0003;
      default: return (idx >= 4 && idx < 4 + ND) ? 32'hFFFF_FFFF : 32'd0;
    endcase
  endfunction

  // kind: 0 idle, 1 read, 2 write. One bus cycle, then every output is compared.
  task automatic step(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic bsy, input logic dn,
                      input logic rwe, input logic [3:0] ridx, input logic [31:0] rdat);
    logic [31:0] idx, bm, exp_rd, nv, irq_exp;
    logic        exp_err, exp_go, rd, wr;
    idx = addr >> 2;
    rd  = (kind == 1);
    wr  = (kind == 2);
    bm  = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    exp_rd = 32'd0;
    if (idx == 32'(4 + ND))   exp_rd = {30'd0, m_go_prev, bsy};
    else if (idx < 32'(NW))   exp_rd = m_w[idx];
    exp_err = ((rd || wr) && idx >= 32'(NW)) || (wr && idx < 4 && bsy);
    exp_go  = wr && idx == 0 && !bsy && be[1] && wd[8];

    valid = (kind != 0); rd0_wr1 = wr; address = addr; wr_data = wd; byte_en = be;
    busy = bsy; done = dn; rx_we = rwe; rx_idx = ridx; rx_data = rdat;
    @(posedge clk); #1;
    valid = 1'b0; done = 1'b0; rx_we = 1'b0;

    chk("rd_valid", 32'(rd_valid), 32'(rd));
    if (rd) chk("rd_data", rd_data, exp_rd);
    chk("err", 32'(err), 32'(exp_err));
    chk("go", 32'(go), 32'(exp_go));

    if (wr && !exp_err && idx < 32'(NW) && idx != 32'(4 + ND) && idx != 32'(5 + ND)) begin
      nv = ((m_w[idx] & ~bm) | (wd & bm)) & field_mask(int'(idx));
      if (idx == 3 && nv == 0) nv = 32'd1;
      m_w[idx] = nv;
    end
    if (wr && idx == 32'(5 + ND)) m_w[5 + ND] = m_w[5 + ND] & ~(wd & bm & 32'd3);
    if (rwe && ridx < ND) m_w[4 + ridx] = rdat;
    m_w[5 + ND] = m_w[5 + ND] | {30'd0, exp_err, dn};
    m_go_prev = exp_go;

    chk("mode", 32'(mode), m_w[0]);
    chk("flash_addr", 32'(flash_addr), m_w[1]);
    chk("xfer_len", 32'(xfer_len), m_w[2]);
    chk("clk_div", 32'(clk_div), m_w[3]);
    for (int k = 0; k < ND; k++) chk("tx_data", tx_data[32*k +: 32], m_w[4 + k]);
    irq_exp = ((m_w[5 + ND] & m_w[6 + ND]) != 0) ? 32'd1 : 32'd0;
`ifdef SPI_REG_BANK_IRQ_EN
    chk("irq", 32'(irq), irq_exp);
`else
    if (irq_exp > 32'd1) $display("note: model irq out of range");
`endif
  endtask

  task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] be, input logic bsy);
    step(2, 32'(idx) << 2, d, be, bsy, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic rd(input int idx);
    step(1, 32'(idx) << 2, 32'd0, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic idle(input logic dn);
    step(0, 32'd0, 32'd0, 4'h0, 1'b0, dn, 1'b0, 4'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int          kind, idx;
    rst_n = 1'b0; valid = 1'b0; rd0_wr1 = 1'b0; address = '0; wr_data = '0; byte_en = '0;
    busy = 1'b0; done = 1'b0; rx_we = 1'b0; rx_idx = '0; rx_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_go", 32'(go), 32'd0);
    chk("reset_clk_div", 32'(clk_div), 32'd1);
    chk("reset_ready", 32'(ready), 32'd1);
    rst_n = 1'b1;

    // Every mapped word after reset; idle in between proves single-cycle rd_valid.
    for (int i = 0; i < NW; i++) begin
      rd(i);
      chk("reset_word", rd_data, (i == 3) ? 32'd1 : 32'd0);
      idle(1'b0);
    end

    // Byte strobes.
    wr(4, 32'hA5A5_A5A5, 4'b0101, 1'b0);
    rd(4);
    chk("data0_bytes", rd_data, 32'h00A5_00A5);

    // GO pulse, then GO while busy.
    wr(0, 32'h0000_0105, 4'b0011, 1'b0);
    chk("go_pulse", 32'(go), 32'd1);
    idle(1'b0);
    chk("go_once", 32'(go), 32'd0);
    wr(0, 32'h0000_0100, 4'b0011, 1'b1);
    chk("go_busy_err", 32'(err), 32'd1);
    rd(5 + ND);
    chk("int_stat_err", rd_data, 32'd2);

    // DONE sticky, INT_EN, W1C.
    wr(5 + ND, 32'd3, 4'h1, 1'b0);
    wr(6 + ND, 32'd1, 4'h1, 1'b0);
    idle(1'b1);
    rd(5 + ND);
    chk("int_stat_done", rd_data, 32'd1);
    wr(5 + ND, 32'd1, 4'h1, 1'b0);
    rd(5 + ND);
    chk("int_stat_cleared", rd_data, 32'd0);
    // Set and clear of DONE in the same cycle: set wins.
    step(2, 32'(5 + ND) << 2, 32'd1, 4'h1, 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    rd(5 + ND);
    chk("set_wins", rd_data, 32'd1);

    // Engine write beats bus write on the same data word.
    step(2, 32'd5 << 2, 32'h1111_1111, 4'hF, 1'b0, 1'b0, 1'b1, 4'd1, 32'h2222_2222);
    rd(5);
    chk("rx_collision", rd_data, 32'h2222_2222);
    // Read racing an engine write returns the old word.
    step(1, 32'd6 << 2, 32'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h3333_3333);
    chk("rx_read_old", rd_data, 32'd0);
    step(0, 32'd0, 32'd0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd9, 32'hDEAD_BEEF);

    // Out of map, CLK_DIV clamp, busy-dropped config write, STATUS.
    rd(NW);
    chk("oob_rd_data", rd_data, 32'd0);
    chk("oob_rd_valid", 32'(rd_valid), 32'd1);
    chk("oob_err", 32'(err), 32'd1);
    step(2, 32'hFFFF_FFF0, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    wr(3, 32'd0, 4'hF, 1'b0);
    rd(3);
    chk("clk_div_zero", rd_data, 32'd1);
    wr(1, 32'hFFFF_FFFF, 4'hF, 1'b1);
    step(1, 32'(4 + ND) << 2, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    chk("status_busy", rd_data, 32'd1);
    wr(4 + ND, 32'hFFFF_FFFF, 4'hF, 1'b0);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      kind = int'($urandom_range(0, 2));
      idx  = int'($urandom_range(0, NW + 1));
      a    = (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 30) == 0) a = $urandom | 32'h8000_0000;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = d & 32'h0000_01FF;
      step(kind, a, d, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 4) == 0),
           4'($urandom_range(0, 15)), $urandom);
    end

    // Reset in the middle of a GO pulse and a read response.
    wr(0, 32'h0000_0100, 4'b0010, 1'b0);
    chk("go_before_rst", 32'(go), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_go", 32'(go), 32'd0);
    chk("rst_clk_div", 32'(clk_div), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    rd(4 + ND);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_tx_data", tx_data[31:0], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
